noc_request_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 30 +++
 rtl/req_fifo.sv | 49 ++++
 rtl/noc_request_arbiter.sv | 113 +++++++++++
 tb/tb_noc_request_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Packet layout constants and helpers shared by the NoC request arbiter.
// Latency: none (types/functions only).
// Backpressure: n/a.
package noc_pkg;

  localparam int DATA_W    = 6;
  localparam int PKT_W     = DATA_W + 5;
  localparam int SRC_LSB   = 3;
  localparam int DEST_LSB  = 1;
  localparam int VALID_BIT = 0;

  // Destination node is the regid bank: regid/16 for a 6-bit regid.
  function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] regid);
    return regid[DATA_W-1 -: 2];
  endfunction

  // Packet, MSB to LSB: data, source id, dest, valid.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [DATA_W-1:0] data,
                                                input logic [1:0]        id,
                                                input logic [1:0]        dest);
    logic [PKT_W-1:0] p;
    p                     = '0;
    p[PKT_W-1 -: DATA_W]  = data;
    p[SRC_LSB +: 2]       = id;
    p[DEST_LSB +: 2]      = dest;
    p[VALID_BIT]          = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Per-source request FIFO, FIFO_DEPTH entries of DATA_W bits.
// Latency: a push is visible at dout/empty one edge later (no bypass).
// Backpressure: full blocks push; pop on empty is ignored; push+pop together keep occupancy.
// Ports: clk, reset (async, active-high), push/din, pop/dout, full, empty.
module req_fifo #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_request_arbiter.sv
// Round-robin merge of NUM_REQ regid request FIFOs onto one NoC injection port.
// Latency: push at edge N -> write=1 at edge N+1 earliest; one packet per cycle.
// Backpressure: per-source req_ready (FIFO not full); NoC full/almost_full gate issue.
// Ports: clk, reset (async, active-high), id, req_valid/req_data/req_ready,
//        full, almost_full, dataOut, write; stall_cnt when NOC_ARB_STALL_CNT_EN is defined.
module noc_request_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 6,
  parameter int WIDTH      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                id,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  input  logic                      almost_full,
  output logic [WIDTH-1:0]          dataOut,
  output logic                      write
`ifdef NOC_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  import noc_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] pop;
  logic [DATA_W-1:0]  head [NUM_REQ];
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant;
  logic               any_req;
  logic               can_issue;
  logic               issue;
  logic [DATA_W-1:0]  grant_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    // The FIFO ignores push while full, so this equals req_valid & req_ready.
    req_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid[i]),
      .din   (req_data[i*DATA_W +: DATA_W]),
      .pop   (pop[i]),
      .dout  (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
    assign req_ready[i] = ~fifo_full[i];
  end

  // A write already in flight takes the NoC's last free slot, so with
  // write high we may only issue again if more than one slot is free.
  assign can_issue = (write & ~almost_full) | (~write & ~full);
  assign issue     = can_issue & any_req;

  // First non-empty FIFO at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PW-1:0] scan;
    grant   = '0;
    any_req = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = ptr + PW'(k);
      if (!any_req && !fifo_empty[scan]) begin
        grant   = scan;
        any_req = 1'b1;
      end
    end
  end

  assign grant_data = head[grant];

  always_comb begin
    pop = '0;
    if (issue) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= '0;
      write   <= 1'b0;
      ptr     <= '0;
    end else if (issue) begin
      write   <= 1'b1;
      dataOut <= make_pkt(grant_data, id, dest_of(grant_data));
      ptr     <= grant + PW'(1);
    end else begin
      write   <= 1'b0;
    end
  end

`ifdef NOC_ARB_STALL_CNT_EN
  // Cycles where work was waiting but the NoC refused it; saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (any_req && !can_issue && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_request_arbiter.sv
// Directed bench for noc_request_arbiter: reset/idle, single request, round-robin
// order, NoC flow control, source FIFO full and mid-stream reset.
module tb_noc_request_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  id;
  logic [3:0]  req_valid;
  logic [23:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        almost_full;
  logic [10:0] dataOut;
  logic        write;
`ifdef NOC_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [10:0] pkts [$];

  noc_request_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .id          (id),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .almost_full (almost_full),
    .dataOut     (dataOut),
    .write       (write)
`ifdef NOC_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every packet the NoC would accept.
  always @(negedge clk) begin
    if (!reset && write) pkts.push_back(dataOut);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet from field definitions: {regid, src id, regid/16, valid}.
  function automatic logic [10:0] exp_pkt(input logic [5:0] d, input logic [1:0] sid);
    return {d, sid, d[5:4], 1'b1};
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    full        = 1'b0;
    almost_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    pkts.delete();
  endtask

  task automatic push_all(input logic [5:0] d0, input logic [5:0] d1,
                          input logic [5:0] d2, input logic [5:0] d3);
    req_data  = {d3, d2, d1, d0};
    req_valid = 4'b1111;
    tick();
    req_valid = 4'b0000;
  endtask

  logic [5:0] rr_dat [4];
  int         order2 [4];
  int         sent;
  logic       rdy;
  logic       vld;

  initial begin
    reset       = 1'b1;
    id          = 2'd1;
    req_valid   = '0;
    req_data    = '0;
    full        = 1'b0;
    almost_full = 1'b0;
    #1;
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_data", {21'd0, dataOut}, 32'd0);
    check("reset_ready", {28'd0, req_ready}, 32'hF);
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_write", {31'd0, write}, 32'd0);
      check("idle_data", {21'd0, dataOut}, 32'd0);
      check("idle_ready", {28'd0, req_ready}, 32'hF);
    end
`ifdef NOC_ARB_STALL_CNT_EN
    check("idle_stall", {16'd0, stall_cnt}, 32'd0);
`endif

    // Single request: source 2, regid 37 -> {100101,01,10,1} = 11'h4AD.
    pkts.delete();
    req_data[12 +: 6] = 6'd37;
    req_valid         = 4'b0100;
    tick();
    req_valid = 4'b0000;
    check("single_no_bypass", {31'd0, write}, 32'd0);
    tick();
    check("single_write", {31'd0, write}, 32'd1);
    check("single_data", {21'd0, dataOut}, 32'h4AD);
    tick();
    check("single_write_drop", {31'd0, write}, 32'd0);
    check("single_data_hold", {21'd0, dataOut}, 32'h4AD);

    // Round-robin from ptr=0: order 0,1,2,3.
    do_reset();
    rr_dat = '{6'd10, 6'd20, 6'd30, 6'd40};
    push_all(rr_dat[0], rr_dat[1], rr_dat[2], rr_dat[3]);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr0_write", {31'd0, write}, 32'd1);
      check("rr0_data", {21'd0, dataOut}, {21'd0, exp_pkt(rr_dat[k], 2'd1)});
    end
    tick();
    check("rr0_idle", {31'd0, write}, 32'd0);

    // Move ptr to 2 with one grant on source 1, then order 2,3,0,1.
    req_data[6 +: 6] = 6'd9;
    req_valid        = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    check("rr_ptr_move", {21'd0, dataOut}, {21'd0, exp_pkt(6'd9, 2'd1)});
    rr_dat = '{6'd17, 6'd34, 6'd51, 6'd60};
    order2 = '{2, 3, 0, 1};
    push_all(rr_dat[0], rr_dat[1], rr_dat[2], rr_dat[3]);
    check("rr2_no_bypass", {31'd0, write}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr2_write", {31'd0, write}, 32'd1);
      check("rr2_data", {21'd0, dataOut}, {21'd0, exp_pkt(rr_dat[order2[k]], 2'd1)});
    end
    tick();
    check("rr2_idle", {31'd0, write}, 32'd0);

    // Flow control: full holds everything, almost_full with write in flight stalls.
    do_reset();
    full = 1'b1;
    req_data  = {6'd0, 6'd0, 6'd50, 6'd5};
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      check("fc_full_hold", {31'd0, write}, 32'd0);
      if (c < 2) tick();
    end
    full = 1'b0;
    tick();
    check("fc_resume_write", {31'd0, write}, 32'd1);
    check("fc_resume_data", {21'd0, dataOut}, {21'd0, exp_pkt(6'd5, 2'd1)});
    almost_full = 1'b1;
    tick();
    check("fc_af_stall", {31'd0, write}, 32'd0);
    almost_full = 1'b0;
    tick();
    check("fc_second_write", {31'd0, write}, 32'd1);
    check("fc_second_data", {21'd0, dataOut}, {21'd0, exp_pkt(6'd50, 2'd1)});
    tick();
    check("fc_idle", {31'd0, write}, 32'd0);
    check("fc_pkt_count", pkts.size(), 32'd2);
    check("fc_pkt0", {21'd0, pkts[0]}, {21'd0, exp_pkt(6'd5, 2'd1)});
    check("fc_pkt1", {21'd0, pkts[1]}, {21'd0, exp_pkt(6'd50, 2'd1)});
`ifdef NOC_ARB_STALL_CNT_EN
    check("fc_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // Source 0 FIFO full: regids 0..5 while the NoC is full, then drain.
    do_reset();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      full             = (c < 6);
      vld              = (sent < 6);
      req_valid        = {3'b000, vld};
      req_data[5:0]    = 6'(sent);
      rdy              = req_ready[0];
      if (c == 0) check("ff_ready_first", {31'd0, rdy}, 32'd1);
      if (c == 4) begin
        check("ff_ready_drop", {31'd0, rdy}, 32'd0);
        check("ff_accepted", sent, 32'd4);
      end
      if (c == 5) check("ff_ready_hold", {31'd0, rdy}, 32'd0);
      tick();
      if (vld && rdy) sent++;
    end
    req_valid = '0;
    check("ff_all_sent", sent, 32'd6);
    check("ff_idle", {31'd0, write}, 32'd0);
    check("ff_pkt_count", pkts.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check("ff_pkt_order", {21'd0, pkts[k]}, {21'd0, exp_pkt(6'(k), 2'd1)});
    end

    // Reset while a packet is on the wire and FIFOs still hold requests.
    do_reset();
    full = 1'b1;
    push_all(6'd11, 6'd22, 6'd33, 6'd44);
    tick();
    full = 1'b0;
    tick();
    check("mid_pre_write", {31'd0, write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_write_zero", {31'd0, write}, 32'd0);
    check("mid_data_zero", {21'd0, dataOut}, 32'd0);
    check("mid_ready_all", {28'd0, req_ready}, 32'hF);
`ifdef NOC_ARB_STALL_CNT_EN
    check("mid_stall_zero", {16'd0, stall_cnt}, 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    pkts.delete();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mid_quiet", {31'd0, write}, 32'd0);
    end
    check("mid_no_pkts", pkts.size(), 32'd0);
    // Fresh request after reset: source 3, regid 63 -> 11'h7EF.
    req_data[18 +: 6] = 6'd63;
    req_valid         = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    check("mid_new_write", {31'd0, write}, 32'd1);
    check("mid_new_data", {21'd0, dataOut}, 32'h7EF);
    tick();
    check("mid_new_idle", {31'd0, write}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
